// File: rtl/j1_pkg.sv
// Shared J1 definitions for the fetch stage: opcode constants, the NOP
// encoding used as the IF/ID bubble, and the prefetch queue entry type.
package j1_pkg;

  localparam int J1_DW = 16;
  localparam int J1_AW = 13;

  // Top three bits of an unconditional jump.
  localparam logic [2:0] J1_OP_JMP = 3'b000;

  // ALU op "T -> T" with no stack effect; loaded into IF/ID on a bubble.
  localparam logic [J1_DW-1:0] J1_NOP = 16'h6000;

  typedef struct packed {
    logic [J1_AW-1:0] addr;
    logic [J1_DW-1:0] inst;
  } fetch_entry_t;

  // True when the word is a J1 unconditional jump.
  function automatic logic j1_is_jmp(input logic [J1_DW-1:0] inst);
    return inst[15:13] == J1_OP_JMP;
  endfunction

endpackage

// File: rtl/if_fetch_fifo.sv
// Two-entry prefetch queue of {addr, inst}. Head is taken straight from the
// entry registers so the consumer sees registered state. Flush empties the
// queue without touching the stored words.
module if_fetch_fifo #(
  parameter int AW = 13,
  parameter int DW = 16
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          flush,
  input  logic          push,
  input  logic [AW-1:0] push_addr,
  input  logic [DW-1:0] push_inst,
  input  logic          pop,
  output logic [AW-1:0] head_addr,
  output logic [DW-1:0] head_inst,
  output logic          head_valid,
  output logic [1:0]    count,
  output logic          full
);

  logic       rd_ptr_reg, rd_ptr_next;
  logic [1:0] cnt_reg, cnt_next;
  logic       wr_ptr;
  logic       do_push, do_pop;

  assign do_push = push && (cnt_reg != 2'd2);
  assign do_pop  = pop && (cnt_reg != 2'd0);
  // With one entry stored the free slot is the other one.
  assign wr_ptr  = rd_ptr_reg ^ (cnt_reg == 2'd1);

  genvar gi;
  generate
    for (gi = 0; gi < 2; gi++) begin : g_entry
      logic [AW-1:0] addr_reg;
      logic [DW-1:0] inst_reg;
      // Entry storage: written only when it is the current write slot.
      always_ff @(posedge clk) begin
        if (!rst_n) begin
          addr_reg <= '0;
          inst_reg <= '0;
        end else if (do_push && (wr_ptr == 1'(gi))) begin
          addr_reg <= push_addr;
          inst_reg <= push_inst;
        end
      end
    end
  endgenerate

  // Occupancy and read pointer update; flush wins over push/pop.
  always_comb begin
    cnt_next    = cnt_reg + {1'b0, do_push} - {1'b0, do_pop};
    rd_ptr_next = rd_ptr_reg ^ do_pop;
    if (flush) begin
      cnt_next    = 2'd0;
      rd_ptr_next = 1'b0;
    end
  end

  // Pointer/count registers.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cnt_reg    <= 2'd0;
      rd_ptr_reg <= 1'b0;
    end else begin
      cnt_reg    <= cnt_next;
      rd_ptr_reg <= rd_ptr_next;
    end
  end

  assign head_addr  = rd_ptr_reg ? g_entry[1].addr_reg : g_entry[0].addr_reg;
  assign head_inst  = rd_ptr_reg ? g_entry[1].inst_reg : g_entry[0].inst_reg;
  assign head_valid = (cnt_reg != 2'd0);
  assign count      = cnt_reg;
  assign full       = (cnt_reg == 2'd2);

endmodule

// File: rtl/if_fetch_unit.sv
// J1 instruction-fetch stage: PC generation, credit-limited in-order memory
// requests, a 2-entry prefetch queue and redirect handling with drop counting.
// Optional feature: IF_STATIC_PREDICT_EN enables in-fetch unconditional-jump
// redirection; without it pred_taken_o is tied low.
module if_fetch_unit
  import j1_pkg::*;
#(
  parameter int            DW     = 16,
  parameter int            AW     = 13,
  parameter logic [AW-1:0] RST_PC = '0
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          jump_flag_i,
  input  logic [AW-1:0] jump_addr_i,
  input  logic          hold_i,
  output logic          imem_req_o,
  output logic [AW-1:0] imem_addr_o,
  input  logic          imem_gnt_i,
  input  logic          imem_rvalid_i,
  input  logic [DW-1:0] imem_rdata_i,
  output logic [DW-1:0] inst_o,
  output logic [AW-1:0] inst_addr_o,
  output logic          inst_valid_o,
  output logic          pred_taken_o
);

  logic [AW-1:0] pc_reg, pc_next;
  logic [1:0]    out_cnt_reg, out_cnt_next;
  logic [1:0]    drop_cnt_reg, drop_cnt_next;
  logic          tag_wr_reg, tag_rd_reg;
  logic [1:0]    q_cnt;
  logic          q_full;
  logic          credit_ok, issue, rvalid_ok, push, pop;
  logic          redirect;
  logic [AW-1:0] redirect_addr;
  logic [AW-1:0] tag_head;

`ifdef IF_STATIC_PREDICT_EN
  logic pred_hit;
  assign pred_hit      = inst_valid_o && j1_is_jmp(inst_o);
  assign pred_taken_o  = pred_hit;
  // External redirect wins; a predicted jump redirects only when it pops.
  assign redirect      = jump_flag_i || (pred_hit && !hold_i);
  assign redirect_addr = jump_flag_i ? jump_addr_i : AW'(inst_o[12:0]);
`else
  assign pred_taken_o  = 1'b0;
  assign redirect      = jump_flag_i;
  assign redirect_addr = jump_addr_i;
`endif

  // Two credits shared between in-flight requests and queued words.
  assign credit_ok   = ({1'b0, out_cnt_reg} + {1'b0, q_cnt}) < 3'd2;
  assign imem_req_o  = rst_n && !redirect && credit_ok;
  assign imem_addr_o = pc_reg;
  assign issue       = imem_req_o && imem_gnt_i;
  // Responses with nothing outstanding (pre-reset traffic) are ignored.
  assign rvalid_ok   = imem_rvalid_i && (out_cnt_reg != 2'd0);
  assign push        = rvalid_ok && (drop_cnt_reg == 2'd0) && !redirect;
  assign pop         = inst_valid_o && !hold_i && !jump_flag_i;

  // In-order address tags for granted requests, read back on each response.
  genvar gi;
  generate
    for (gi = 0; gi < 2; gi++) begin : g_tag
      logic [AW-1:0] tag_reg;
      // Capture the PC of a granted request into its tag slot.
      always_ff @(posedge clk) begin
        if (!rst_n) begin
          tag_reg <= '0;
        end else if (issue && (tag_wr_reg == 1'(gi))) begin
          tag_reg <= pc_reg;
        end
      end
    end
  endgenerate

  assign tag_head = tag_rd_reg ? g_tag[1].tag_reg : g_tag[0].tag_reg;

  // Next PC and counters; a redirect turns every in-flight response into a drop.
  always_comb begin
    pc_next       = pc_reg;
    out_cnt_next  = out_cnt_reg + {1'b0, issue} - {1'b0, rvalid_ok};
    drop_cnt_next = drop_cnt_reg;
    if (redirect) begin
      pc_next       = redirect_addr;
      drop_cnt_next = out_cnt_reg - {1'b0, rvalid_ok};
    end else begin
      if (issue) pc_next = pc_reg + AW'(1);
      if (rvalid_ok && (drop_cnt_reg != 2'd0)) drop_cnt_next = drop_cnt_reg - 2'd1;
    end
  end

  // PC, counter and tag-pointer registers.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      pc_reg       <= RST_PC;
      out_cnt_reg  <= 2'd0;
      drop_cnt_reg <= 2'd0;
      tag_wr_reg   <= 1'b0;
      tag_rd_reg   <= 1'b0;
    end else begin
      pc_reg       <= pc_next;
      out_cnt_reg  <= out_cnt_next;
      drop_cnt_reg <= drop_cnt_next;
      tag_wr_reg   <= tag_wr_reg ^ issue;
      tag_rd_reg   <= tag_rd_reg ^ rvalid_ok;
    end
  end

  if_fetch_fifo #(.AW(AW), .DW(DW)) u_fifo (
    .clk        (clk),
    .rst_n      (rst_n),
    .flush      (redirect),
    .push       (push),
    .push_addr  (tag_head),
    .push_inst  (imem_rdata_i),
    .pop        (pop && !redirect),
    .head_addr  (inst_addr_o),
    .head_inst  (inst_o),
    .head_valid (inst_valid_o),
    .count      (q_cnt),
    .full       (q_full)
  );

  // The credit rule must make a push into a full queue impossible.
  assert property (@(posedge clk) disable iff (!rst_n) push |-> !q_full)
    else $error("push into full prefetch queue");

endmodule
